sparse_expander: RTL and testbench

SPARSE_EXPANDER -- requirements
Module: sparse_expander

---
 rtl/sparse_expander.sv | 222 ++++++++++++++++++++++
 tb/tb_sparse_expander.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_expander.sv
// sparse_expander: inverse of a dense-coalescing filter. The k-th accepted dense
// element is placed at the position of the (k+1)-th set bit of the latched mask.
// Optional feature macro: SPARSE_EXPANDER_OVERFLOW_FLAG_EN adds overflowError.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   maskValid/maskReady     bitmask handshake, bitmask = positions that are dense
//   denseValid/denseReady   dense beat handshake, denseData lanes, denseCount valid lanes
//   sparseValid/sparseReady expanded vector handshake, sparseOutput + sparseMask
//   overflowError           sticky excess-lane flag (only with the macro)
module sparse_expander #(
    parameter int BITMASK_LENGTH = 16,
    parameter int INDEX_BITWIDTH = 5,
    parameter int ELEMENT_WIDTH  = 8,
    parameter int DENSE_LANES    = 4
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    maskValid,
    output logic                                    maskReady,
    input  logic [BITMASK_LENGTH-1:0]               bitmask,
    input  logic                                    denseValid,
    output logic                                    denseReady,
    input  logic [ELEMENT_WIDTH*DENSE_LANES-1:0]    denseData,
    input  logic [INDEX_BITWIDTH-1:0]               denseCount,
    output logic                                    sparseValid,
    input  logic                                    sparseReady,
    output logic [ELEMENT_WIDTH*BITMASK_LENGTH-1:0] sparseOutput,
    output logic [BITMASK_LENGTH-1:0]               sparseMask
`ifdef SPARSE_EXPANDER_OVERFLOW_FLAG_EN
    ,
    output logic                                    overflowError
`endif
);

    localparam int L  = BITMASK_LENGTH;
    localparam int IW = INDEX_BITWIDTH;
    localparam int CW = INDEX_BITWIDTH + 1;
    localparam int EW = ELEMENT_WIDTH;
    localparam int DL = DENSE_LANES;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [L-1:0]        r_mask;
    logic [IW-1:0]       r_n;
    logic [IW-1:0]       r_fill;
    logic [EW-1:0]       r_buf [L];

    logic                w_mask_acc;
    logic                w_beat_acc;
    logic [IW-1:0]       w_pop;
    logic [IW-1:0]       w_cnt;
    logic [IW-1:0]       w_rem;
    logic [IW-1:0]       w_adv;
    logic                w_done;
    logic [IW-1:0]       w_prefix [L];
    logic [EW*L-1:0]     w_sparse;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (maskValid) begin
                    w_next = (w_pop == '0) ? S_EMIT : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (denseValid && w_done) begin
                    w_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (sparseReady) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (registered state only, never the valid inputs)
    // ------------------------------------------------------------------
    always_comb begin
        maskReady   = 1'b0;
        denseReady  = 1'b0;
        sparseValid = 1'b0;
        unique case (r_state)
            S_IDLE:    maskReady   = 1'b1;
            S_COLLECT: denseReady  = 1'b1;
            S_EMIT:    sparseValid = 1'b1;
            default:   maskReady   = 1'b0;
        endcase
    end

    assign w_mask_acc = maskValid  && maskReady;
    assign w_beat_acc = denseValid && denseReady;

    // ------------------------------------------------------------------
    // Beat arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        logic [IW-1:0] v_pop;
        v_pop = '0;
        for (int i = 0; i < L; i++) begin
            v_pop = v_pop + IW'(bitmask[i]);
        end
        w_pop = v_pop;
    end

    // Oversized counts behave as a full beat.
    assign w_cnt  = (denseCount > IW'(DL)) ? IW'(DL) : denseCount;
    // r_fill never exceeds r_n, so the difference cannot underflow.
    assign w_rem  = r_n - r_fill;
    assign w_adv  = (w_cnt < w_rem) ? w_cnt : w_rem;
    assign w_done = (w_cnt >= w_rem);

    // ------------------------------------------------------------------
    // Mask, popcount and fill count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask <= '0;
            r_n    <= '0;
            r_fill <= '0;
        end else if (w_mask_acc) begin
            r_mask <= bitmask;
            r_n    <= w_pop;
            r_fill <= '0;
        end else if (w_beat_acc) begin
            r_fill <= r_fill + w_adv;
        end
    end

    // ------------------------------------------------------------------
    // Element buffer: lane j lands in slot F+j, lanes past N are dropped.
    // Slot-major loops keep every index constant.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < L; s++) begin
                r_buf[s] <= '0;
            end
        end else if (w_beat_acc) begin
            for (int s = 0; s < L; s++) begin
                for (int j = 0; j < DL; j++) begin
                    if ((IW'(j) < w_cnt) &&
                        (({1'b0, r_fill} + CW'(j)) == CW'(s)) &&
                        (CW'(s) < {1'b0, r_n})) begin
                        r_buf[s] <= denseData[j*EW +: EW];
                    end
                end
            end
        end
    end

`ifdef SPARSE_EXPANDER_OVERFLOW_FLAG_EN
    // ------------------------------------------------------------------
    // Sticky flag: raw count larger than the room left or than the lanes.
    // ------------------------------------------------------------------
    logic r_ovf;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_beat_acc &&
                     ((denseCount > w_rem) ||
                      (denseCount > IW'(DL)))) begin
            r_ovf <= 1'b1;
        end
    end

    assign overflowError = r_ovf;
`endif

    // ------------------------------------------------------------------
    // Expansion: inclusive prefix count selects the buffer slot.
    // ------------------------------------------------------------------
    always_comb begin
        logic [IW-1:0] v_run;
        v_run = '0;
        for (int i = 0; i < L; i++) begin
            v_run       = v_run + IW'(r_mask[i]);
            w_prefix[i] = v_run;
        end
    end

    always_comb begin
        w_sparse = '0;
        for (int i = 0; i < L; i++) begin
            for (int k = 0; k < L; k++) begin
                if (r_mask[i] && (w_prefix[i] == IW'(k + 1))) begin
                    w_sparse[i*EW +: EW] = r_buf[k];
                end
            end
        end
    end

    assign sparseOutput = w_sparse;
    assign sparseMask   = r_mask;

endmodule

// File: tb/tb_sparse_expander.sv
// tb_sparse_expander: table-driven and randomized checks of sparse_expander
// against a queue-based expansion model.
module tb_sparse_expander;

    localparam int L  = 16;
    localparam int IW = 5;
    localparam int EW = 8;
    localparam int DL = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            maskValid;
    logic            maskReady;
    logic [L-1:0]    bitmask;
    logic            denseValid;
    logic            denseReady;
    logic [EW*DL-1:0] denseData;
    logic [IW-1:0]   denseCount;
    logic            sparseValid;
    logic            sparseReady;
    logic [EW*L-1:0] sparseOutput;
    logic [L-1:0]    sparseMask;
`ifdef SPARSE_EXPANDER_OVERFLOW_FLAG_EN
    logic            overflowError;
`endif

    int errors = 0;
    int checks = 0;

    // Model state: accepted elements in order and expected sticky overflow.
    logic [7:0] acc_q[$];
    logic       model_ovf;

    typedef struct {
        logic [15:0] mask;
        int          cnt;
        int          hold;
        logic [7:0]  base;
        int          exp_beats;
    } vec_t;

    vec_t tv [6];

    sparse_expander #(
        .BITMASK_LENGTH(L),
        .INDEX_BITWIDTH(IW),
        .ELEMENT_WIDTH (EW),
        .DENSE_LANES   (DL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .maskValid   (maskValid),
        .maskReady   (maskReady),
        .bitmask     (bitmask),
        .denseValid  (denseValid),
        .denseReady  (denseReady),
        .denseData   (denseData),
        .denseCount  (denseCount),
        .sparseValid (sparseValid),
        .sparseReady (sparseReady),
        .sparseOutput(sparseOutput),
        .sparseMask  (sparseMask)
`ifdef SPARSE_EXPANDER_OVERFLOW_FLAG_EN
        ,
        .overflowError(overflowError)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [135:0] act,
                       input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected vector: walk positions, hand out queued elements in order.
    function automatic logic [127:0] expand(input logic [15:0] m);
        logic [127:0] r;
        int k;
        r = '0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                r[i*8 +: 8] = acc_q[k];
                k++;
            end
        end
        return r;
    endfunction

    // mode >= 0: fixed count, incrementing data from base
    // mode == -1: random count 0..4, random data
    // mode == -2: random count 0..7, random data
    task automatic run_vec(input logic [15:0] m, input int mode,
                           input int hold, input logic [7:0] base,
                           input int exp_beats);
        int n, beats, guard, c, ce, used;
        logic [7:0] nxt;
        logic [127:0] exp_out;
        n = $countones(m);
        nxt = base;
        acc_q.delete();
        beats = 0;
        @(negedge clock);
        maskValid = 1'b1;
        bitmask = m;
        guard = 0;
        while (!maskReady && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("mask_handshake_timeout", 136'(guard < 20), 136'(1));
        @(negedge clock);
        maskValid = 1'b0;
        bitmask = 16'($urandom);
        guard = 0;
        while (acc_q.size() < n && guard < 100) begin
            if (mode == -1) c = $urandom_range(0, 4);
            else if (mode == -2) c = $urandom_range(0, 7);
            else c = mode;
            ce = (c > DL) ? DL : c;
            denseValid = 1'b1;
            denseCount = c[IW-1:0];
            for (int j = 0; j < DL; j++) begin
                denseData[j*8 +: 8] = (mode < 0) ? 8'($urandom)
                                                 : nxt + 8'(j);
            end
            if (denseReady) begin
                used = acc_q.size();
                if (c > DL || c > n - used) model_ovf = 1'b1;
                for (int j = 0; j < ce; j++) begin
                    acc_q.push_back(denseData[j*8 +: 8]);
                end
                beats++;
                nxt = nxt + 8'(ce);
            end
            @(negedge clock);
            guard++;
        end
        denseValid = 1'b0;
        denseCount = '0;
        chk("dense_timeout", 136'(guard < 100), 136'(1));
        chk("valid_latency", 136'(sparseValid), 136'(1));
        chk("dense_ready_in_emit", 136'(denseReady), 136'(0));
        if (exp_beats >= 0) begin
            chk("beats_accepted", 136'(beats), 136'(exp_beats));
        end
        exp_out = expand(m);
        chk("sparse_output", 136'(sparseOutput), 136'(exp_out));
        chk("sparse_mask", 136'(sparseMask), 136'(m));
`ifdef SPARSE_EXPANDER_OVERFLOW_FLAG_EN
        chk("overflow_flag", 136'(overflowError), 136'(model_ovf));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("emit_hold_stable",
                136'({sparseValid, maskReady, sparseOutput}),
                136'({1'b1, 1'b0, exp_out}));
        end
        sparseReady = 1'b1;
        @(negedge clock);
        sparseReady = 1'b0;
        chk("after_handshake",
            136'({sparseValid, maskReady, denseReady}),
            136'(3'b010));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{16'h0004, 1, 0, 8'hA5, 1};
        tv[1] = '{16'hFFFF, 4, 1, 8'h00, 4};
        tv[2] = '{16'h0000, 0, 0, 8'h00, 0};
        tv[3] = '{16'h0013, 4, 5, 8'h01, 1};
        tv[4] = '{16'h00F0, 3, 2, 8'h10, 2};
        tv[5] = '{16'h8001, 2, 0, 8'h20, 1};

        reset       = 1'b1;
        maskValid   = 1'b0;
        bitmask     = '0;
        denseValid  = 1'b0;
        denseData   = '0;
        denseCount  = '0;
        sparseReady = 1'b0;
        model_ovf   = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_handshakes",
            136'({maskReady, denseReady, sparseValid}), 136'(3'b100));
        chk("reset_output", 136'(sparseOutput), 136'(0));
        chk("reset_mask", 136'(sparseMask), 136'(0));
`ifdef SPARSE_EXPANDER_OVERFLOW_FLAG_EN
        chk("reset_overflow", 136'(overflowError), 136'(0));
`endif
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(tv[i].mask, tv[i].cnt, tv[i].hold,
                    tv[i].base, tv[i].exp_beats);
        end

        // Reset after two of four beats: vector is dropped.
        @(negedge clock);
        maskValid = 1'b1;
        bitmask = 16'hFFFF;
        @(negedge clock);
        maskValid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            denseValid = 1'b1;
            denseCount = 5'd4;
            denseData = $urandom;
            @(negedge clock);
        end
        denseValid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_ovf = 1'b0;
        chk("midreset_handshakes",
            136'({maskReady, denseReady, sparseValid}), 136'(3'b100));
        chk("midreset_output", 136'(sparseOutput), 136'(0));
        chk("midreset_mask", 136'(sparseMask), 136'(0));
`ifdef SPARSE_EXPANDER_OVERFLOW_FLAG_EN
        chk("midreset_overflow", 136'(overflowError), 136'(0));
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("midreset_no_valid", 136'(sparseValid), 136'(0));
        end
        run_vec(16'hFFFF, 4, 0, 8'h40, 4);

        // Randomized vectors against the model.
        for (int r = 0; r < 24; r++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (r % 8 == 7) m = '0;
            run_vec(m, (r % 2 == 0) ? -1 : -2,
                    $urandom_range(0, 3), 8'h00, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
